// File: rtl/record_part_1.sv
// Song recorder: times each key press on the live keyboard and writes
// {note, duration} to the next song-memory slot, in the format that the
// auto-play sequencer reads back.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   record_en       level enable for recording
//   clear           one-cycle pulse, restart recording at address 0
//   key_on, key     live keyboard state (key 0 = no note)
//   wr_en           one-cycle song-memory write strobe
//   wr_addr         write location (held until the next write)
//   wr_note         note to store (held until the next write)
//   wr_duration     press length in clk cycles (held until the next write)
//   note_count      notes stored since reset or clear
//   full            note_count has reached DEPTH
//   recording       a press is currently being timed
module record_part_1 #(
    parameter int DEPTH     = 25,
    parameter int MIN_PRESS = 1000000,
    parameter int DUR_W     = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             record_en,
    input  logic             clear,
    input  logic             key_on,
    input  logic [3:0]       key,
    output logic             wr_en,
    output logic [4:0]       wr_addr,
    output logic [3:0]       wr_note,
    output logic [DUR_W-1:0] wr_duration,
    output logic [4:0]       note_count,
    output logic             full,
    output logic             recording
);

    typedef enum logic {
        IDLE,
        PRESS
    } state_t;

    localparam logic [4:0]       LAST_ADDR = 5'(DEPTH - 1);
    localparam logic [4:0]       DEPTH_CNT = 5'(DEPTH);
    localparam logic [DUR_W-1:0] MIN_DUR   = DUR_W'(MIN_PRESS);

    state_t             state_q, state_d;
    logic [DUR_W-1:0]   ctr_q, ctr_d;
    logic [3:0]         note_q, note_d;
    logic [4:0]         addr_q, addr_d;
    logic [4:0]         count_q, count_d;
    logic               full_q, full_d;
    logic               rec_q, rec_d;
    logic               wr_en_q, wr_en_d;
    logic [4:0]         wr_addr_q, wr_addr_d;
    logic [3:0]         wr_note_q, wr_note_d;
    logic [DUR_W-1:0]   wr_dur_q, wr_dur_d;

    logic start;
    logic hold;

    assign start = record_en && key_on && (key != 4'd0) && !full_q;
    assign hold  = key_on && (key == note_q) && record_en;

    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        note_d    = note_q;
        addr_d    = addr_q;
        count_d   = count_q;
        full_d    = full_q;
        rec_d     = rec_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_note_d = wr_note_q;
        wr_dur_d  = wr_dur_q;

        if (clear) begin
            // Abandons any press in progress, even one ending this edge.
            state_d = IDLE;
            rec_d   = 1'b0;
            ctr_d   = '0;
            addr_d  = '0;
            count_d = '0;
            full_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        note_d  = key;
                        ctr_d   = {{(DUR_W-1){1'b0}}, 1'b1};
                        state_d = PRESS;
                        rec_d   = 1'b1;
                    end
                end
                PRESS: begin
                    if (hold) begin
                        if (ctr_q != '1) begin
                            ctr_d = ctr_q + 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        rec_d   = 1'b0;
                        // Short presses are treated as key bounce.
                        if (ctr_q >= MIN_DUR) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_note_d = note_q;
                            wr_dur_d  = ctr_q;
                            addr_d    = (addr_q == LAST_ADDR) ?
                                        5'd0 : addr_q + 5'd1;
                            count_d   = count_q + 5'd1;
                            full_d    = (count_q + 5'd1) == DEPTH_CNT;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ctr_q     <= '0;
            note_q    <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            rec_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_note_q <= '0;
            wr_dur_q  <= '0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            note_q    <= note_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            rec_q     <= rec_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_note_q <= wr_note_d;
            wr_dur_q  <= wr_dur_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_note     = wr_note_q;
    assign wr_duration = wr_dur_q;
    assign note_count  = count_q;
    assign full        = full_q;
    assign recording   = rec_q;

endmodule
